sl_perceptron_top: RTL and testbench

Single-layer perceptron compute block.
- An on-chip weight RAM is loaded over a simple memory port.
- Multi-lane input data beats are multiplied by the stored weights and accumulated over one full vector.
- The finished dot product is published as a status sum, together with a threshold-comparator decision.
- It sits between a host register/memory interface and a streaming data source.

---
 rtl/sl_perceptron_top.sv | 79 +++++++
 tb/tb_sl_perceptron_top.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sl_perceptron_top.sv
// sl_perceptron_top: single-layer perceptron with a loadable weight RAM.
// Multi-lane beats are multiplied by the weights and accumulated; each completed vector is published with a threshold decision.
module sl_perceptron_top #(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int VECTOR_LENGTH  = 64,
    parameter int SUM_WIDTH      = 24
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   data_valid,
    input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
    input  logic                                   mem_wen,
    input  logic                                   mem_ren,
    input  logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
    input  logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
    output logic [WEIGHTS_WIDTH-1:0]               mem_rdata,
    input  logic [SUM_WIDTH-1:0]                   cfg_ai_threshold,
    output logic [SUM_WIDTH-1:0]                   status_ai_sum,
    output logic                                   status_ai_comparator
);
    localparam int IDXW = $clog2(VECTOR_LENGTH);
    localparam logic [MEM_ADDR_WIDTH-1:0] DEPTH = MEM_ADDR_WIDTH'(VECTOR_LENGTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(VECTOR_LENGTH - DATA_IN_LANES);
    localparam logic [IDXW-1:0] STEP = IDXW'(DATA_IN_LANES);

    logic signed [WEIGHTS_WIDTH-1:0] r_weights [VECTOR_LENGTH];
    logic [WEIGHTS_WIDTH-1:0]        r_rdata;
    logic [IDXW-1:0]                 r_idx;
    logic signed [SUM_WIDTH-1:0]     r_acc;
    logic signed [SUM_WIDTH-1:0]     r_sum;
    logic signed [SUM_WIDTH-1:0]     w_partial;
    logic                            w_addr_ok;
    logic                            w_last;

    assign w_addr_ok = mem_addr < DEPTH;
    assign w_last    = r_idx == LAST_IDX;

    // Lanes are zero-extended, weights sign-extended, so each product wraps at SUM_WIDTH.
    always_comb begin
        w_partial = '0;
        for (int i = 0; i < DATA_IN_LANES; i++)
            w_partial = w_partial
                + SUM_WIDTH'($signed({1'b0, data_in[i*DATA_IN_WIDTH +: DATA_IN_WIDTH]}))
                * SUM_WIDTH'(r_weights[r_idx + IDXW'(i)]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VECTOR_LENGTH; i++)
                r_weights[i] <= '0;
            r_rdata <= '0;
        end else begin
            if (mem_wen && w_addr_ok)
                r_weights[mem_addr[IDXW-1:0]] <= mem_wdata;
            if (mem_ren)
                r_rdata <= w_addr_ok ? r_weights[mem_addr[IDXW-1:0]] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
            r_acc <= '0;
            r_sum <= '0;
        end else if (data_valid) begin
            r_idx <= w_last ? '0 : r_idx + STEP;
            r_acc <= w_last ? '0 : r_acc + w_partial;
            if (w_last)
                r_sum <= r_acc + w_partial;
        end
    end

    assign mem_rdata            = r_rdata;
    assign status_ai_sum        = r_sum;
    assign status_ai_comparator = r_sum > $signed(cfg_ai_threshold);
endmodule

// File: tb/tb_sl_perceptron_top.sv
// tb_sl_perceptron_top: directed checks of weight RAM, accumulation, lane order, gaps and reset.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_sl_perceptron_top;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_valid = 1'b0;
    logic [31:0] data_in = '0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [7:0]  mem_wdata = '0;
    logic [7:0]  mem_rdata;
    logic [23:0] cfg_ai_threshold = '0;
    logic [23:0] status_ai_sum;
    logic        status_ai_comparator;
    logic [31:0] v [16];
    int          n_cmp = 0;
    int          n_err = 0;

    sl_perceptron_top dut (
        .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data_in(data_in),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cfg_ai_threshold(cfg_ai_threshold),
        .status_ai_sum(status_ai_sum), .status_ai_comparator(status_ai_comparator)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        mem_wen = 1'b1; mem_addr = 16'(a); mem_wdata = d;
        @(negedge clk);
        mem_wen = 1'b0;
    endtask

    task automatic rd(input int a);
        mem_ren = 1'b1; mem_addr = 16'(a);
        @(negedge clk);
        mem_ren = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input int gap);
        data_valid = 1'b1; data_in = d;
        @(negedge clk);
        data_valid = 1'b0; data_in = '0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic fill_w(input logic [7:0] d);
        for (int k = 0; k < 64; k++) wr(k, d);
    endtask

    task automatic run_vec(input int maxgap);
        for (int b = 0; b < 16; b++) beat(v[b], b == 15 ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    initial begin
        cfg_ai_threshold = 24'hFFFFFF;
        #12;
        check("rst_sum", 32'(status_ai_sum), 32'h0);
        check("rst_rdata", 32'(mem_rdata), 32'h0);
        check("rst_cmp_thr_m1", 32'(status_ai_comparator), 32'h1);
        cfg_ai_threshold = 24'h0;
        #1;
        check("rst_cmp_thr_0", 32'(status_ai_comparator), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        fill_w(8'h01);
        for (int b = 0; b < 16; b++) v[b] = 32'h01010101;
        for (int b = 0; b < 15; b++) beat(v[b], 0);
        check("hold_before_last", 32'(status_ai_sum), 32'h0);
        beat(v[15], 0);
        check("ones_sum", 32'(status_ai_sum), 32'd64);
        cfg_ai_threshold = 24'd63;
        #1;
        check("cmp_thr63", 32'(status_ai_comparator), 32'h1);
        cfg_ai_threshold = 24'd64;
        #1;
        check("cmp_thr64", 32'(status_ai_comparator), 32'h0);
        @(negedge clk);

        fill_w(8'hFF);
        for (int b = 0; b < 16; b++) v[b] = 32'hFFFFFFFF;
        run_vec(0);
        check("neg_sum", 32'(status_ai_sum), 32'h00FFC040);
        cfg_ai_threshold = 24'h0;
        #1;
        check("neg_cmp_thr0", 32'(status_ai_comparator), 32'h0);
        cfg_ai_threshold = 24'hFFC03F;
        #1;
        check("neg_cmp_thr_below", 32'(status_ai_comparator), 32'h1);
        @(negedge clk);

        wr(3, 8'h5A);
        rd(3);
        check("rd_addr3", 32'(mem_rdata), 32'h5A);
        rd(100);
        check("rd_oor", 32'(mem_rdata), 32'h0);
        rd(3);
        mem_addr = 16'd100;
        @(negedge clk);
        check("rd_hold", 32'(mem_rdata), 32'h5A);
        wr(64, 8'h77);
        rd(0);
        check("wr_oor_ignored", 32'(mem_rdata), 32'hFF);
        mem_wen = 1'b1; mem_ren = 1'b1; mem_addr = 16'd3; mem_wdata = 8'h11;
        @(negedge clk);
        mem_wen = 1'b0; mem_ren = 1'b0;
        check("rbw_old", 32'(mem_rdata), 32'h5A);
        rd(3);
        check("rbw_new", 32'(mem_rdata), 32'h11);

        for (int k = 0; k < 64; k++) wr(k, 8'(k));
        for (int b = 0; b < 16; b++) v[b] = 32'h0;
        v[0] = 32'h00000001;
        run_vec(0);
        check("lane0_w0", 32'(status_ai_sum), 32'h0);
        v[0] = 32'h01000000;
        run_vec(0);
        check("lane3_w3", 32'(status_ai_sum), 32'd3);
        v[0] = 32'h0;
        v[15] = 32'h04030201;
        run_vec(0);
        check("last_beat_lanes", 32'(status_ai_sum), 32'd620);

        fill_w(8'h01);
        for (int b = 0; b < 16; b++) v[b] = 32'h01010101;
        run_vec(3);
        check("gaps_sum", 32'(status_ai_sum), 32'd64);
        run_vec(0);
        check("b2b_sum", 32'(status_ai_sum), 32'd64);

        rd(0);
        for (int b = 0; b < 8; b++) beat(32'h01010101, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sum", 32'(status_ai_sum), 32'h0);
        check("async_rst_rdata", 32'(mem_rdata), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(5);
        check("rst_weights_clear", 32'(mem_rdata), 32'h0);
        fill_w(8'h02);
        run_vec(1);
        check("reload_sum", 32'(status_ai_sum), 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
